// File: rtl/sobel_edge_packer.sv
// Thresholds Sobel result magnitudes into edge flags and packs them LSB-first into 32-bit words.
// Optional edge counter is built when SOBEL_EDGE_COUNT_EN is defined.
module sobel_edge_packer #(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_thresh,
    input  logic        i_result_vld,
    input  logic [23:0] i_result_data,
    output logic        i_result_busy,
    output logic        o_edge_vld,
    output logic [31:0] o_edge_data,
    input  logic        o_edge_busy,
    output logic        o_frame_done,
    output logic [31:0] o_edge_count
);

    localparam int N     = WIDTH * HEIGHT;
    localparam int PIX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(N - 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      acc;
    logic [31:0]      out_reg;
    logic [4:0]       bit_cnt;
    logic [PIX_W-1:0] pix_cnt;
    logic             last_q;
    logic             frame_done;
    logic [7:0]       thr_q;

    logic             out_vld;
    logic             at_word_end;
    logic             accept;
    logic             drain;
    logic             complete;
    logic             flag;
    logic [7:0]       thr_use;
    logic [31:0]      word_nxt;
    logic             unused_data;

    assign unused_data = ^i_result_data[23:8];

    assign out_vld     = (state == HOLD);
    assign at_word_end = (bit_cnt == 5'd31) || (pix_cnt == LAST_PIX);
    // Busy depends only on registers and reset, so downstream stalls never reach upstream combinationally.
    assign i_result_busy = i_rst || (out_vld && at_word_end);

    assign accept   = i_result_vld && !i_result_busy;
    assign drain    = out_vld && !o_edge_busy;
    assign complete = accept && at_word_end;

    // Pixel 0 uses the live threshold; the rest of the frame uses the value latched with it.
    assign thr_use  = (pix_cnt == '0) ? i_thresh : thr_q;
    assign flag     = (i_result_data[7:0] >= thr_use);
    assign word_nxt = acc | (32'(flag) << bit_cnt);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (complete) state_nxt = HOLD;
            end
            HOLD: begin
                if (complete)   state_nxt = HOLD;
                else if (drain) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc        <= '0;
            out_reg    <= '0;
            bit_cnt    <= '0;
            pix_cnt    <= '0;
            last_q     <= 1'b0;
            frame_done <= 1'b0;
            thr_q      <= '0;
        end else begin
            frame_done <= drain && last_q;
            if (accept) begin
                if (pix_cnt == '0) thr_q <= i_thresh;
                if (at_word_end) begin
                    out_reg <= word_nxt;
                    last_q  <= (pix_cnt == LAST_PIX);
                    acc     <= '0;
                    bit_cnt <= '0;
                end else begin
                    acc     <= word_nxt;
                    bit_cnt <= bit_cnt + 5'd1;
                end
                pix_cnt <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + 1'b1;
            end
        end
    end

    assign o_edge_vld   = out_vld;
    assign o_edge_data  = out_reg;
    assign o_frame_done = frame_done;

`ifdef SOBEL_EDGE_COUNT_EN
    logic [31:0] edge_cnt;

    // Restarts on pixel 0 (counting that pixel's own flag) and saturates at all-ones.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            edge_cnt <= '0;
        end else if (accept) begin
            if (pix_cnt == '0)               edge_cnt <= 32'(flag);
            else if (flag && edge_cnt != '1) edge_cnt <= edge_cnt + 32'd1;
        end
    end

    assign o_edge_count = edge_cnt;
`else
    assign o_edge_count = '0;
`endif

endmodule

// File: tb/tb_sobel_edge_packer.sv
// Scoreboard bench for sobel_edge_packer: an 8x4 instance and a 5x1 instance driven with directed frames.
module tb_sobel_edge_packer;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [7:0]  thr     [2];
    logic        r_vld   [2];
    logic [23:0] r_data  [2];
    logic        r_busy  [2];
    logic        e_vld   [2];
    logic [31:0] e_data  [2];
    logic        e_busy  [2];
    logic        done    [2];
    logic [31:0] count   [2];

    exp_t q0[$];
    exp_t q1[$];

    int total  = 0;
    int passed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sobel_edge_packer #(.WIDTH(8), .HEIGHT(4)) u_a (
        .i_clk(clk), .i_rst(rst), .i_thresh(thr[0]),
        .i_result_vld(r_vld[0]), .i_result_data(r_data[0]), .i_result_busy(r_busy[0]),
        .o_edge_vld(e_vld[0]), .o_edge_data(e_data[0]), .o_edge_busy(e_busy[0]),
        .o_frame_done(done[0]), .o_edge_count(count[0])
    );

    sobel_edge_packer #(.WIDTH(5), .HEIGHT(1)) u_b (
        .i_clk(clk), .i_rst(rst), .i_thresh(thr[1]),
        .i_result_vld(r_vld[1]), .i_result_data(r_data[1]), .i_result_busy(r_busy[1]),
        .o_edge_vld(e_vld[1]), .o_edge_data(e_data[1]), .o_edge_busy(e_busy[1]),
        .o_frame_done(done[1]), .o_edge_count(count[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef SOBEL_EDGE_COUNT_EN
        return 32'(n);
`else
        return 32'(n * 0);
`endif
    endfunction

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input int d, input logic [7:0] mag);
        int n;
        r_vld[d]  = 1'b1;
        r_data[d] = {16'hA5C3, mag};
        n = 0;
        while (r_busy[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            $display("FAIL send_timeout[%0d]: busy stuck, required release within 100 cycles", d);
        end
        @(negedge clk);
    endtask

    task automatic push(input int d, input logic [31:0] data, input logic last);
        exp_t e;
        e.data = data;
        e.last = last;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_mon
        logic prev_xfer;
        logic prev_last;
        exp_t e;
        initial begin
            prev_xfer = 1'b0;
            prev_last = 1'b0;
            forever begin
                @(negedge clk);
                #2;
                if (prev_xfer)    check($sformatf("frame_done[%0d]", g), 32'(done[g]), 32'(prev_last));
                else if (done[g]) check($sformatf("spurious_done[%0d]", g), 32'(done[g]), 32'd0);
                prev_xfer = 1'b0;
                if (e_vld[g] && !e_busy[g]) begin
                    if ((g == 0 ? q0.size() : q1.size()) == 0) begin
                        total++;
                        $display("FAIL unexpected_word[%0d]: got %h, required no word", g, e_data[g]);
                    end else begin
                        e = (g == 0) ? q0.pop_front() : q1.pop_front();
                        check($sformatf("word[%0d]", g), e_data[g], e.data);
                        prev_xfer = 1'b1;
                        prev_last = e.last;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            thr[d] = 8'd0; r_vld[d] = 1'b0; r_data[d] = '0; e_busy[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_vld[%0d]", d),   32'(e_vld[d]), 32'd0);
            check($sformatf("rst_data[%0d]", d),  e_data[d], 32'd0);
            check($sformatf("rst_done[%0d]", d),  32'(done[d]), 32'd0);
            check($sformatf("rst_count[%0d]", d), count[d], 32'd0);
            check($sformatf("rst_busy[%0d]", d),  32'(r_busy[d]), 32'd1);
        end
        rst = 1'b0;
        @(negedge clk);

        // Frame 1: alternating 100/50 against 90
        thr[0] = 8'd90;
        push(0, 32'h5555_5555, 1'b1);
        for (int i = 0; i < 32; i++) send(0, (i % 2 == 1) ? 8'd50 : 8'd100);
        check("latency_a", 32'(e_vld[0]), 32'd1);
        r_vld[0] = 1'b0;
        check("count_f1", count[0], exp_cnt(16));
        repeat (2) @(negedge clk);

        // Frame 2: equality boundary, threshold changed after pixel 0
        push(0, 32'h0000_0005, 1'b1);
        for (int i = 0; i < 32; i++) begin
            send(0, (i == 0 || i == 2) ? 8'd90 : (i == 1) ? 8'd89 : 8'd50);
            if (i == 0) thr[0] = 8'd10;
        end
        r_vld[0] = 1'b0;
        check("count_f2", count[0], exp_cnt(2));

        // Frame 3: new threshold 10 now in effect
        push(0, 32'hFFFF_FFFD, 1'b1);
        for (int i = 0; i < 32; i++) send(0, (i == 0) ? 8'd10 : (i == 1) ? 8'd9 : 8'd50);
        r_vld[0] = 1'b0;
        check("count_f3", count[0], exp_cnt(31));
        repeat (2) @(negedge clk);

        // Frames 4/5: downstream stalled across the word boundary
        e_busy[0] = 1'b1;
        push(0, 32'h0000_FFFF, 1'b1);
        push(0, 32'hFFFF_0000, 1'b1);
        for (int i = 0; i < 32; i++) send(0, (i < 16) ? 8'd50 : 8'd0);
        r_vld[0] = 1'b0;
        check("count_f4", count[0], exp_cnt(16));
        for (int i = 0; i < 31; i++) send(0, (i >= 16) ? 8'd50 : 8'd0);
        r_vld[0]  = 1'b1;
        r_data[0] = {16'hA5C3, 8'd50};
        check("stall_busy", 32'(r_busy[0]), 32'd1);
        repeat (3) @(negedge clk);
        check("stall_busy_hold", 32'(r_busy[0]), 32'd1);
        check("stall_vld_hold", 32'(e_vld[0]), 32'd1);
        check("stall_data_hold", e_data[0], 32'h0000_FFFF);
        e_busy[0] = 1'b0;
        n = 0;
        while (r_busy[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("stall_release", 32'(r_busy[0]), 32'd0);
        @(negedge clk);
        r_vld[0] = 1'b0;
        check("count_f5", count[0], exp_cnt(16));
        repeat (3) @(negedge clk);

        // Frame 6 aborted by reset after 17 pixels; frame 7 must pack from bit 0
        for (int i = 0; i < 17; i++) send(0, 8'd50);
        r_vld[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_vld", 32'(e_vld[0]), 32'd0);
        check("midrst_data", e_data[0], 32'd0);
        check("midrst_count", count[0], 32'd0);
        check("midrst_busy", 32'(r_busy[0]), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        thr[0] = 8'd90;
        push(0, 32'hAAAA_AAAA, 1'b1);
        for (int i = 0; i < 32; i++) send(0, (i % 2 == 1) ? 8'd100 : 8'd50);
        r_vld[0] = 1'b0;
        check("count_f7", count[0], exp_cnt(16));

        // 5x1 instance: partial frame-final word, then a fresh frame
        thr[1] = 8'd90;
        push(1, 32'h0000_001F, 1'b1);
        push(1, 32'h0000_001F, 1'b1);
        for (int i = 0; i < 5; i++) send(1, 8'd200);
        check("latency_b", 32'(e_vld[1]), 32'd1);
        check("count_b_f1", count[1], exp_cnt(5));
        send(1, 8'd200);
        check("count_b_restart", count[1], exp_cnt(1));
        for (int i = 0; i < 4; i++) send(1, 8'd200);
        r_vld[1] = 1'b0;

        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_q0", 32'(q0.size()), 32'd0);
        check("drain_q1", 32'(q1.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
